// File: rtl/mem_line_responder.sv
// rtl/mem_line_responder.sv - line-organised backing memory answering cache refill/writeback requests after a fixed latency
module mem_line_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int MEM_ADDR_LEN  = 10,
  parameter int LATENCY       = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rd_req,
  input  logic                                wr_req,
  input  logic [MEM_ADDR_LEN-1:0]             addr,
  input  logic [32*(2**LINE_ADDR_LEN)-1:0]    wr_line,
  output logic [32*(2**LINE_ADDR_LEN)-1:0]    rd_line,
  output logic                                gnt,
  output logic                                busy,
  output logic [31:0]                         rd_count,
  output logic [31:0]                         wr_count
);

  localparam int LINE_W = 32 * (2 ** LINE_ADDR_LEN);
  localparam int DEPTH  = 2 ** MEM_ADDR_LEN;
  // Counter is loaded with LATENCY-1 so the array operation lands exactly LATENCY edges after accept
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [7:0]              cnt;
  logic [MEM_ADDR_LEN-1:0] addr_q;
  logic [LINE_W-1:0]       wr_line_q;
  logic                    op_wr_q;
  logic                    do_op;

  // Backing array; deliberately outside the reset domain so reset never clears stored lines
  logic [LINE_W-1:0]       mem [0:DEPTH-1];

  assign do_op = (state == BUSY) && (cnt == 8'd0);

  // Array write on the completing edge of an accepted write
  always_ff @(posedge clk) begin
    if (do_op && op_wr_q) begin
      mem[addr_q] <= wr_line_q;
    end
  end

  // Request FSM: accept, count down latency, pulse gnt for one cycle, update traffic counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      addr_q    <= '0;
      wr_line_q <= '0;
      op_wr_q   <= 1'b0;
      rd_line   <= '0;
      gnt       <= 1'b0;
      busy      <= 1'b0;
      rd_count  <= 32'd0;
      wr_count  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          gnt <= 1'b0;
          if (rd_req || wr_req) begin
            addr_q    <= addr;
            wr_line_q <= wr_line;
            // A simultaneous read request is dropped in favour of the writeback
            op_wr_q   <= wr_req;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) begin
            if (op_wr_q) begin
              wr_count <= wr_count + 32'd1;
            end else begin
              rd_line  <= mem[addr_q];
              rd_count <= rd_count + 32'd1;
            end
            gnt   <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          gnt   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// tb/tb_mem_line_responder.sv - randomized self-checking bench for mem_line_responder with a transaction-level reference model
module tb_mem_line_responder;

  localparam int LAT = 4;
  localparam int LW  = 256;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] wr_line = '0;
  logic [LW-1:0] rd_line;
  logic          gnt, busy;
  logic [31:0]   rd_count, wr_count;

  logic          rd_req1 = 1'b0, wr_req1 = 1'b0;
  logic [AW-1:0] addr1 = '0;
  logic [LW-1:0] wr_line1 = '0;
  logic [LW-1:0] rd_line1;
  logic          gnt1, busy1;
  logic [31:0]   rd_count1, wr_count1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  mem_line_responder #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wr_line(wr_line),
    .rd_line(rd_line), .gnt(gnt), .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
  );

  mem_line_responder #(.LINE_ADDR_LEN(3), .MEM_ADDR_LEN(AW), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .rd_req(rd_req1), .wr_req(wr_req1), .addr(addr1), .wr_line(wr_line1),
    .rd_line(rd_line1), .gnt(gnt1), .busy(busy1), .rd_count(rd_count1), .wr_count(wr_count1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction in flight, described by its accept edge number
  logic [LW-1:0] m_mem [int];
  int            edge_n = 0;
  bit            m_active = 1'b0;
  int            m_t0 = 0;
  bit            m_wr = 1'b0;
  int            m_addr = 0;
  logic [LW-1:0] m_data = '0;
  logic [LW-1:0] m_rd_line = '0;
  logic [31:0]   m_rdc = 0, m_wrc = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active  = 1'b0;
      m_rd_line = '0;
      m_rdc     = 0;
      m_wrc     = 0;
    end else begin
      edge_n++;
      if (m_active && edge_n == m_t0 + LAT) begin
        if (m_wr) begin
          m_mem[m_addr] = m_data;
          m_wrc++;
        end else begin
          m_rd_line = m_mem.exists(m_addr) ? m_mem[m_addr] : '0;
          m_rdc++;
        end
      end
      if ((!m_active || edge_n >= m_t0 + LAT + 2) && (rd_req || wr_req)) begin
        m_active = 1'b1;
        m_t0     = edge_n;
        m_wr     = wr_req;
        m_addr   = int'(addr);
        m_data   = wr_line;
      end
    end
  end

  // Compare DUT outputs against the model every cycle, mid-period
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt",      LW'(gnt),      LW'(m_active && edge_n == m_t0 + LAT));
      check("busy",     LW'(busy),     LW'(m_active && edge_n >= m_t0 && edge_n <= m_t0 + LAT));
      check("rd_line",  rd_line,       m_rd_line);
      check("rd_count", LW'(rd_count), LW'(m_rdc));
      check("wr_count", LW'(wr_count), LW'(m_wrc));
    end
  end

  // Raise a request, hold until gnt is seen, drop it, then idle one cycle
  task automatic xact(input bit rd, input bit wr, input int a, input logic [LW-1:0] d,
                      input bit drop_early, output int waited, output int gcyc);
    rd_req  = rd;
    wr_req  = wr;
    addr    = AW'(a);
    wr_line = d;
    waited  = 0;
    forever begin
      @(negedge clk);
      waited++;
      if (drop_early && waited == 1) begin
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        addr    = AW'($urandom);
        wr_line = '1;
      end
      if (gnt) break;
      if (waited > 60) begin
        tests++;
        fails++;
        $display("FAIL gnt_timeout: got no gnt after %0d cycles expected %0d", waited, LAT + 1);
        break;
      end
    end
    gcyc   = cyc;
    rd_req = 1'b0;
    wr_req = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    int w, g1, g2;
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_rd_count", LW'(rd_count), '0);
    check("reset_busy", LW'(busy), '0);

    // Write then read line 5
    xact(1'b0, 1'b1, 5, a5, 1'b0, w, g1);
    check("wr_latency", LW'(w), LW'(LAT + 1));
    rd_req = 1'b1;
    addr   = AW'(5);
    w = 0;
    do begin @(negedge clk); w++; end while (!gnt && w < 60);
    check("rd_latency", LW'(w), LW'(LAT + 1));
    check("rd_line_a5", rd_line, a5);
    rd_req = 1'b0;
    @(negedge clk);
    check("wr_count_1", LW'(wr_count), LW'(1));
    check("rd_count_1", LW'(rd_count), LW'(1));

    // Both requests at once: write wins
    xact(1'b1, 1'b1, 7, LW'(32'h1234), 1'b0, w, g1);
    check("both_wr_count", LW'(wr_count), LW'(2));
    check("both_rd_count", LW'(rd_count), LW'(1));
    xact(1'b1, 1'b0, 7, '0, 1'b0, w, g1);
    check("line7", rd_line, LW'(32'h1234));

    // Reset two cycles into a write to line 3
    wr_req  = 1'b1;
    addr    = AW'(3);
    wr_line = LW'(32'hFFFF);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    wr_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_wr_count", LW'(wr_count), '0);
    check("rst_rd_line", rd_line, '0);
    xact(1'b1, 1'b0, 3, '0, 1'b0, w, g1);
    check("line3_after_rst", rd_line, '0);

    // Request dropped during BUSY still completes with latched data
    xact(1'b0, 1'b1, 9, LW'(32'h55), 1'b1, w, g1);
    check("drop_latency", LW'(w), LW'(LAT + 1));
    xact(1'b1, 1'b0, 9, '0, 1'b0, w, g1);
    check("line9", rd_line, LW'(32'h55));

    // Back-to-back reads
    xact(1'b1, 1'b0, 1, '0, 1'b0, w, g1);
    xact(1'b1, 1'b0, 2, '0, 1'b0, w, g2);
    check("b2b_spacing", LW'(g2 - g1), LW'(LAT + 2));

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      int  op;
      op = $urandom_range(0, 4);
      xact(op != 1, op != 0, $urandom_range(0, 15), rnd_line(), $urandom_range(0, 4) == 0, w, g1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // LATENCY=1 instance: read of unwritten line 0
    rd_req1 = 1'b1;
    @(negedge clk);
    check("l1_gnt_early", LW'(gnt1), '0);
    check("l1_busy", LW'(busy1), LW'(1));
    rd_req1 = 1'b1;
    @(negedge clk);
    check("l1_gnt", LW'(gnt1), LW'(1));
    check("l1_rd_line", rd_line1, '0);
    check("l1_rd_count", LW'(rd_count1), LW'(1));
    rd_req1 = 1'b0;
    @(negedge clk);
    check("l1_gnt_off", LW'(gnt1), '0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
